// File: rtl/collision_pkg.sv
// Shared types and default sizing for the sprite collision unit.
package collision_pkg;

    localparam int unsigned N_ENEMY_DEF = 4;
    localparam int unsigned MIN_RUN_DEF = 3;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } glb_state_t;

    typedef enum logic {
        ARMED = 1'b0,
        HIT   = 1'b1
    } ch_state_t;

endpackage

// File: rtl/collision_channel.sv
// One enemy channel: overlap run counter, ARMED/HIT state and a one-shot hit pulse.
module collision_channel
    import collision_pkg::*;
#(
    parameter int unsigned MIN_RUN = MIN_RUN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic ov,
    output logic pulse,
    output logic hit
);

    localparam int unsigned RUN_W = $clog2(MIN_RUN + 1);

    ch_state_t        state, state_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic             pulse_nxt;

    // Frame clear has priority over the current pixel's overlap.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        pulse_nxt = 1'b0;
        if (clear) begin
            state_nxt = ARMED;
            run_nxt   = '0;
        end else if (ov) begin
            if (run != RUN_W'(MIN_RUN)) begin
                run_nxt = run + RUN_W'(1);
            end
            if ((state == ARMED) && (run == RUN_W'(MIN_RUN - 1))) begin
                state_nxt = HIT;
                pulse_nxt = 1'b1;
            end
        end else begin
            run_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARMED;
            run   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            pulse <= pulse_nxt;
        end
    end

    assign hit = (state == HIT);

endmodule

// File: rtl/collision_unit.sv
// Player/enemy sprite collision detector with per-frame hit flags and a saturating hit-frame count.
module collision_unit
    import collision_pkg::*;
#(
    parameter int unsigned N_ENEMY = N_ENEMY_DEF,
    parameter int unsigned MIN_RUN = MIN_RUN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               Pclk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               pixel_valid,
    input  logic               player_on,
    input  logic [N_ENEMY-1:0] enemy_on,
    output logic               collision_now,
    output logic [N_ENEMY-1:0] hit_pulse,
    output logic [N_ENEMY-1:0] hit_frame,
    output logic [CNT_W-1:0]   hit_count
);

    glb_state_t         state, state_nxt;
    logic               running;
    logic               frame_clear;
    logic               any_hit;
    logic [N_ENEMY-1:0] ov;
    logic [N_ENEMY-1:0] ch_hit;

    always_comb begin
        state_nxt = state;
        if ((state == WAIT_FRAME) && frame_start) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_nxt;
        end
    end

    // Until the first frame boundary is seen every pixel input is ignored.
    assign running     = (state == RUN);
    assign ov          = {N_ENEMY{running & pixel_valid & player_on}} & enemy_on;
    assign frame_clear = running & frame_start;
    assign any_hit     = |ch_hit;

    for (genvar i = 0; i < N_ENEMY; i++) begin : g_ch
        collision_channel #(
            .MIN_RUN (MIN_RUN)
        ) u_ch (
            .clk   (Pclk),
            .rst_n (rst_n),
            .clear (frame_clear),
            .ov    (ov[i]),
            .pulse (hit_pulse[i]),
            .hit   (ch_hit[i])
        );
    end

    // Frame boundary snapshots channel states; count saturates rather than wrapping.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            collision_now <= 1'b0;
            hit_frame     <= '0;
            hit_count     <= '0;
        end else begin
            collision_now <= |ov;
            if (frame_clear) begin
                hit_frame <= ch_hit;
                if (any_hit && (hit_count != '1)) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_unit.sv
// Randomized and directed bench for collision_unit against a frame-level behavioural model.
module tb_collision_unit;

    localparam int unsigned N   = 4;
    localparam int unsigned MR  = 3;
    localparam int unsigned CW  = 8;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          Pclk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          pixel_valid;
    logic          player_on;
    logic [N-1:0]  enemy_on;
    logic          collision_now;
    logic [N-1:0]  hit_pulse;
    logic [N-1:0]  hit_frame;
    logic [CW-1:0] hit_count;

    always #20 Pclk = ~Pclk;

    collision_unit #(
        .N_ENEMY (N),
        .MIN_RUN (MR),
        .CNT_W   (CW)
    ) dut (
        .Pclk          (Pclk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .pixel_valid   (pixel_valid),
        .player_on     (player_on),
        .enemy_on      (enemy_on),
        .collision_now (collision_now),
        .hit_pulse     (hit_pulse),
        .hit_frame     (hit_frame),
        .hit_count     (hit_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: streak lengths per enemy and whether the enemy was already confirmed this frame.
    bit         started;
    int         streak [N];
    bit         confirmed [N];
    logic       exp_cn;
    logic [N-1:0] exp_pulse;
    logic [N-1:0] exp_frame;
    int         exp_count;

    function automatic void model_reset();
        started   = 1'b0;
        exp_cn    = 1'b0;
        exp_pulse = '0;
        exp_frame = '0;
        exp_count = 0;
        for (int i = 0; i < N; i++) begin
            streak[i]    = 0;
            confirmed[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic fs, input logic pv, input logic po, input logic [N-1:0] en);
        bit any;
        if (!started) begin
            if (fs) started = 1'b1;
            return;
        end
        exp_cn    = pv && po && (en != '0);
        exp_pulse = '0;
        if (fs) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                exp_frame[i] = confirmed[i];
                any          = any | confirmed[i];
                confirmed[i] = 1'b0;
                streak[i]    = 0;
            end
            if (any) exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pv && po && en[i]) begin
                    streak[i]++;
                    if (streak[i] >= int'(MR) && !confirmed[i]) begin
                        confirmed[i] = 1'b1;
                        exp_pulse[i] = 1'b1;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        check("collision_now", 32'(collision_now), 32'(exp_cn));
        check("hit_pulse", 32'(hit_pulse), 32'(exp_pulse));
        check("hit_frame", 32'(hit_frame), 32'(exp_frame));
        check("hit_count", 32'(hit_count), 32'(exp_count));
    endtask

    // Starts and ends on a falling edge; outputs of the edge just taken are checked.
    task automatic step(input logic fs, input logic pv, input logic po, input logic [N-1:0] en);
        frame_start = fs;
        pixel_valid = pv;
        player_on   = po;
        enemy_on    = en;
        @(posedge Pclk);
        model_edge(fs, pv, po, en);
        @(negedge Pclk);
        check_outputs();
    endtask

    task automatic overlap(input int cycles, input logic [N-1:0] en);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b1, 1'b1, en);
    endtask

    task automatic mid_reset();
        #5;
        rst_n = 1'b0;
        #1;
        check("rst_collision_now", 32'(collision_now), 32'd0);
        check("rst_hit_pulse", 32'(hit_pulse), 32'd0);
        check("rst_hit_frame", 32'(hit_frame), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        model_reset();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        player_on   = 1'b0;
        enemy_on    = '0;
        #4;
        rst_n = 1'b1;
        @(negedge Pclk);
        check_outputs();
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        player_on   = 1'b0;
        enemy_on    = '0;
        model_reset();
        repeat (2) @(negedge Pclk);
        check_outputs();
        rst_n = 1'b1;

        // Overlap before the first frame boundary is ignored.
        overlap(4, 4'b0001);
        check("pre_frame_pulse", 32'(hit_pulse), 32'd0);
        check("pre_frame_cn", 32'(collision_now), 32'd0);

        // Single enemy confirms after three pixels.
        step(1'b1, 1'b0, 1'b0, '0);
        overlap(2, 4'b0010);
        check("hit1_early", 32'(hit_pulse), 32'd0);
        overlap(1, 4'b0010);
        check("hit1_pulse", 32'(hit_pulse), 32'b0010);
        step(1'b0, 1'b0, 1'b0, '0);
        check("hit1_once", 32'(hit_pulse), 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("hit1_frame", 32'(hit_frame), 32'b0010);
        check("hit1_count", 32'(hit_count), 32'd1);

        // Broken run never confirms.
        overlap(2, 4'b0001);
        step(1'b0, 1'b1, 1'b1, '0);
        overlap(2, 4'b0001);
        check("gap_pulse", 32'(hit_pulse), 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("gap_frame", 32'(hit_frame), 32'd0);
        check("gap_count", 32'(hit_count), 32'd1);

        // Two channels confirm together, continued overlap ignored.
        overlap(3, 4'b1001);
        check("dual_pulse", 32'(hit_pulse), 32'b1001);
        overlap(10, 4'b1001);
        check("dual_after", 32'(hit_pulse), 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("dual_frame", 32'(hit_frame), 32'b1001);
        check("dual_count", 32'(hit_count), 32'd2);

        // Frame boundary on the third overlapping pixel restarts the run.
        overlap(2, 4'b0100);
        step(1'b1, 1'b1, 1'b1, 4'b0100);
        check("fs_win_pulse", 32'(hit_pulse), 32'd0);
        overlap(2, 4'b0100);
        check("fs_win_restart", 32'(hit_pulse), 32'd0);
        overlap(1, 4'b0100);
        check("fs_win_late_hit", 32'(hit_pulse), 32'b0100);

        // Reset in the middle of a run, then first snapshot lands on the second boundary.
        overlap(2, 4'b0001);
        mid_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        overlap(3, 4'b0001);
        step(1'b1, 1'b0, 1'b0, '0);
        check("post_rst_frame", 32'(hit_frame), 32'b0001);
        check("post_rst_count", 32'(hit_count), 32'd1);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = int'($urandom_range(8, 40));
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));
            for (int k = 0; k < len; k++) begin
                step(1'b0, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), N'($urandom));
            end
            if (f == 20) mid_reset();
        end

        // Saturation of the hit-frame counter.
        for (int f = 0; f < 300; f++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            overlap(3, 4'b0001);
            step(1'b0, 1'b0, 1'b0, '0);
        end
        step(1'b1, 1'b0, 1'b0, '0);
        check("sat_count", 32'(hit_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
